// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier and its initiators (e.g. sqr).
// Holds the FSM state encoding and the default operand width.
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_e;

endpackage : mul_pkg

// File: rtl/mul.sv
// Iterative shift-add unsigned multiplier: one partial product per clock, WIDTH steps per
// operation, with the 2*WIDTH-bit product held stable until the next completed operation.
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     a_bi,
  input  logic [WIDTH-1:0]     b_bi,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic [2*WIDTH-1:0]   y_bo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic [CW-1:0]        ctr_q, ctr_d;

  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   sum;

  // Conditional adder: the maximum result (2^W-1)^2 fits in 2*WIDTH bits, so no carry-out.
  assign partial = b_q[ctr_q] ? ({{WIDTH{1'b0}}, a_q} << ctr_q) : '0;
  assign sum     = acc_q + partial;

  // NOTE: every next-state signal gets its hold value first, so no path through this block
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ctr_d   = ctr_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_bi;
          b_d     = b_bi;
          acc_d   = '0;
          ctr_d   = '0;
          state_d = WORK;
        end
      end
      WORK: begin
        acc_d = sum;
        if (ctr_q == LAST_STEP) begin
          y_d     = sum;
          state_d = IDLE;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together
  // from values sampled at the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ctr_q   <= ctr_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign y_bo   = y_q;

endmodule : mul

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed vector table, random operands against a plain
// arithmetic model, and hand-written sequences for start-while-busy, held start and reset.
module tb_mul;

  localparam int W = 8;
  localparam int LAT = W;
  localparam int MAX_WAIT = 40;

  logic            clk_i;
  logic            rst_i;
  logic [W-1:0]    a_bi;
  logic [W-1:0]    b_bi;
  logic            start_i;
  logic            busy_o;
  logic [2*W-1:0]  y_bo;

  int checks;
  int failures;
  logic [2*W-1:0] y_model;

  mul #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Count negedges with busy high after the accepting edge; returns MAX_WAIT on timeout.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (cyc < MAX_WAIT) begin
      @(negedge clk_i);
      if (!busy_o) break;
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int cyc;
    @(negedge clk_i);
    a_bi = a; b_bi = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_bi = ~a; b_bi = ~b;
    check({name, "_busy_after_start"}, busy_o, 1);
    check({name, "_y_holds_prev"}, y_bo, y_model);
    wait_done(cyc);
    check({name, "_busy_cycles"}, cyc, LAT);
    check({name, "_y"}, y_bo, exp);
    y_model = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    int cyc;
    logic [W-1:0] ra, rb;

    checks = 0; failures = 0; y_model = '0;
    rst_i = 1'b0; start_i = 1'b0; a_bi = '0; b_bi = '0;

    vecs[0] = '{a: 8'h0F, b: 8'h0F, y: 16'h00E1};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, y: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'h5A, y: 16'h0000};
    vecs[3] = '{a: 8'h80, b: 8'h01, y: 16'h0080};

    // Reset held for 3 cycles with start requested: nothing may be accepted.
    start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_busy", busy_o, 0);
    check("reset_y", y_bo, 0);
    start_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_busy", busy_o, 0);
    check("post_reset_y", y_bo, 0);

    for (int i = 0; i < 4; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y);

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, (2*W)'(ra) * (2*W)'(rb));
    end

    // Start while busy must be ignored and must not disturb operands in flight.
    @(negedge clk_i);
    a_bi = 8'h12; b_bi = 8'h34; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    a_bi = 8'hFF; b_bi = 8'hFF; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("ignored_start_y_prev", y_bo, y_model);
    check("ignored_start_busy", busy_o, 1);
    cyc = 3;
    while (cyc < MAX_WAIT) begin
      @(negedge clk_i);
      if (!busy_o) break;
      cyc++;
    end
    check("ignored_start_busy_cycles", cyc, LAT);
    check("ignored_start_y", y_bo, 16'h03A8);
    y_model = 16'h03A8;
    repeat (2) @(negedge clk_i);
    check("ignored_start_no_requeue", busy_o, 0);

    // Start held across completion is re-accepted on the first idle edge with new operands.
    @(negedge clk_i);
    a_bi = 8'h07; b_bi = 8'h09; start_i = 1'b1;
    @(negedge clk_i);
    a_bi = 8'h21; b_bi = 8'h03;
    wait_done(cyc);
    check("held_start_first_cycles", cyc, LAT);
    check("held_start_first_y", y_bo, 16'h003F);
    @(negedge clk_i);
    start_i = 1'b0;
    check("held_start_reaccept_busy", busy_o, 1);
    check("held_start_y_holds", y_bo, 16'h003F);
    wait_done(cyc);
    check("held_start_second_cycles", cyc, LAT);
    check("held_start_second_y", y_bo, 16'h0063);
    y_model = 16'h0063;

    // Reset in the middle of an operation discards it immediately.
    @(negedge clk_i);
    a_bi = 8'h10; b_bi = 8'h10; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("midreset_busy", busy_o, 0);
    check("midreset_y", y_bo, 0);
    y_model = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    run_op("after_reset", 8'h03, 8'h05, 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mul
